// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multicycle RV32I control unit: FSM state encoding,
// opcode/funct constants, ALU control codes, trap cause codes and the branch
// condition helper used in write-back.
package mc_control_fsm_pkg;

    // Controller states. TRAP is absorbing until reset.
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } ctrlState_e;

    // Major opcodes accepted by the unit
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 values for OP / OP-IMM
    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_SLTU   = 3'b011;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_SR     = 3'b101;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    // Only word-sized memory accesses are supported
    localparam logic [2:0] F3_WORD = 3'b010;

    // funct3 values for branches
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct7 values that select the base or alternate (sub/sra) operation
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU control encoding expected by the datapath ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    // Reason the unit halted
    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    // Branch condition from the datapath comparator flags
    function automatic logic branchTaken(input logic [2:0] funct3,
                                         input logic       zero,
                                         input logic       lt,
                                         input logic       ltu);
        logic taken;
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = !zero;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = !lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// Combinational instruction decoder: turns the opcode/funct fields of the
// latched instruction into the ALU operation, operand select, instruction
// class flags and an illegal-encoding flag.
module mc_control_fsm_alu_decoder
    import mc_control_fsm_pkg::*;
#(
    parameter int EN_BRANCH_EXT = 1
) (
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [3:0] aluCtrl_o,
    output logic       aluSrc_o,
    output logic       isLoad_o,
    output logic       isStore_o,
    output logic       isBranch_o,
    output logic       illegal_o
);

    // Decode class, ALU op and legality from the instruction fields
    always_comb begin
        aluCtrl_o  = ALU_ADD;
        aluSrc_o   = 1'b0;
        isLoad_o   = 1'b0;
        isStore_o  = 1'b0;
        isBranch_o = 1'b0;
        illegal_o  = 1'b0;
        case (opcode_i)
            OPC_OP: begin
                if ((funct7_i != F7_BASE) && (funct7_i != F7_ALT)) begin
                    illegal_o = 1'b1;
                end
                case (funct3_i)
                    F3_ADDSUB: aluCtrl_o = funct7_i[5] ? ALU_SUB : ALU_ADD;
                    F3_SLL:    aluCtrl_o = ALU_SLL;
                    F3_SLT:    aluCtrl_o = ALU_SLT;
                    F3_SLTU:   illegal_o = 1'b1;
                    F3_XOR:    aluCtrl_o = ALU_XOR;
                    F3_SR:     aluCtrl_o = funct7_i[5] ? ALU_SRA : ALU_SRL;
                    F3_OR:     aluCtrl_o = ALU_OR;
                    default:   aluCtrl_o = ALU_AND;
                endcase
            end
            OPC_OP_IMM: begin
                aluSrc_o = 1'b1;
                case (funct3_i)
                    F3_ADDSUB: aluCtrl_o = ALU_ADD;
                    F3_SLL: begin
                        aluCtrl_o = ALU_SLL;
                        if (funct7_i != F7_BASE) begin
                            illegal_o = 1'b1;
                        end
                    end
                    F3_SLT:    aluCtrl_o = ALU_SLT;
                    F3_SLTU:   illegal_o = 1'b1;
                    F3_XOR:    aluCtrl_o = ALU_XOR;
                    F3_SR: begin
                        if (funct7_i == F7_BASE) begin
                            aluCtrl_o = ALU_SRL;
                        end else if (funct7_i == F7_ALT) begin
                            aluCtrl_o = ALU_SRA;
                        end else begin
                            illegal_o = 1'b1;
                        end
                    end
                    F3_OR:     aluCtrl_o = ALU_OR;
                    default:   aluCtrl_o = ALU_AND;
                endcase
            end
            OPC_LOAD: begin
                aluSrc_o  = 1'b1;
                isLoad_o  = 1'b1;
                illegal_o = (funct3_i != F3_WORD);
            end
            OPC_STORE: begin
                aluSrc_o  = 1'b1;
                isStore_o = 1'b1;
                illegal_o = (funct3_i != F3_WORD);
            end
            OPC_BRANCH: begin
                aluCtrl_o  = ALU_SUB;
                isBranch_o = 1'b1;
                if ((funct3_i == 3'b010) || (funct3_i == 3'b011)) begin
                    illegal_o = 1'b1;
                end else if ((funct3_i != F3_BEQ) && (EN_BRANCH_EXT == 0)) begin
                    illegal_o = 1'b1;
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control unit for the RV32I datapath. Latches the fetched
// instruction, walks IF/ID/EX/[MEM]/WB with ready handshakes on both memories,
// bounds the data-memory wait, and halts in a sticky TRAP state on illegal
// encodings or a memory timeout.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT   = 15,
    parameter int EN_BRANCH_EXT = 1,
    parameter int ALUCTRL_W     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          instr_i,
    input  logic                 iReady_i,
    input  logic                 dReady_i,
    input  logic                 Zero_i,
    input  logic                 Lt_i,
    input  logic                 Ltu_i,
    output logic [ALUCTRL_W-1:0] ALUCtrl_o,
    output logic                 ALUSrc_o,
    output logic                 loadPC_o,
    output logic                 PCSrc_o,
    output logic                 RegWrite_o,
    output logic                 MemToReg_o,
    output logic                 MemRead_o,
    output logic                 MemWrite_o,
    output logic                 retire_o,
    output logic                 trap_o,
    output logic [1:0]           trap_cause_o
);

    // Wait counter only has to hold 0 .. MEM_TIMEOUT-1
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    ctrlState_e       state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
    logic [1:0]       trapCause_q, trapCause_d;
    logic [3:0]       aluCtrl_q, aluCtrl_d;
    logic             aluSrc_q, aluSrc_d;

    logic [3:0] decAluCtrl;
    logic       decAluSrc;
    logic       decIsLoad;
    logic       decIsStore;
    logic       decIsBranch;
    logic       decIllegal;
    logic       timeoutHit;
    logic       unusedIrBits;

    // Register and immediate fields are consumed by the datapath, not here
    assign unusedIrBits = ^{ir_q[24:15], ir_q[11:7]};

    mc_control_fsm_alu_decoder #(
        .EN_BRANCH_EXT(EN_BRANCH_EXT)
    ) u_decoder (
        .opcode_i  (ir_q[6:0]),
        .funct3_i  (ir_q[14:12]),
        .funct7_i  (ir_q[31:25]),
        .aluCtrl_o (decAluCtrl),
        .aluSrc_o  (decAluSrc),
        .isLoad_o  (decIsLoad),
        .isStore_o (decIsStore),
        .isBranch_o(decIsBranch),
        .illegal_o (decIllegal)
    );

    assign timeoutHit = (MEM_TIMEOUT != 0) && (waitCnt_q == CNT_LAST);

    // Next-state logic: fetch latch, decode/legality, memory wait with timeout
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        waitCnt_d   = waitCnt_q;
        trapCause_d = trapCause_q;
        aluCtrl_d   = aluCtrl_q;
        aluSrc_d    = aluSrc_q;
        case (state_q)
            S_IF: begin
                if (iReady_i) begin
                    ir_d    = instr_i;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                if (decIllegal) begin
                    state_d     = S_TRAP;
                    trapCause_d = TRAP_ILLEGAL;
                end else begin
                    state_d   = S_EX;
                    aluCtrl_d = decAluCtrl;
                    aluSrc_d  = decAluSrc;
                end
            end
            S_EX: begin
                if (decIsLoad || decIsStore) begin
                    state_d   = S_MEM;
                    waitCnt_d = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dReady_i) begin
                    state_d = S_WB;
                end else if (timeoutHit) begin
                    state_d     = S_TRAP;
                    trapCause_d = TRAP_TIMEOUT;
                end else begin
                    waitCnt_d = waitCnt_q + CNT_W'(1);
                end
            end
            S_WB:    state_d = S_IF;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IF;
        endcase
    end

    // State, instruction and decoded-control registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IF;
            ir_q        <= '0;
            waitCnt_q   <= '0;
            trapCause_q <= TRAP_NONE;
            aluCtrl_q   <= '0;
            aluSrc_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            waitCnt_q   <= waitCnt_d;
            trapCause_q <= trapCause_d;
            aluCtrl_q   <= aluCtrl_d;
            aluSrc_q    <= aluSrc_d;
        end
    end

    // Datapath strobes decoded from the current state; flags are sampled only in WB
    always_comb begin
        loadPC_o   = 1'b0;
        PCSrc_o    = 1'b0;
        RegWrite_o = 1'b0;
        MemToReg_o = 1'b0;
        MemRead_o  = 1'b0;
        MemWrite_o = 1'b0;
        retire_o   = 1'b0;
        trap_o     = 1'b0;
        case (state_q)
            S_MEM: begin
                MemRead_o  = decIsLoad;
                MemWrite_o = decIsStore;
            end
            S_WB: begin
                loadPC_o   = 1'b1;
                retire_o   = 1'b1;
                RegWrite_o = !(decIsStore || decIsBranch);
                MemToReg_o = decIsLoad;
                PCSrc_o    = decIsBranch && branchTaken(ir_q[14:12], Zero_i, Lt_i, Ltu_i);
            end
            S_TRAP:  trap_o = 1'b1;
            default: trap_o = 1'b0;
        endcase
    end

    assign ALUCtrl_o    = ALUCTRL_W'(aluCtrl_q);
    assign ALUSrc_o     = aluSrc_q;
    assign trap_cause_o = trapCause_q;

endmodule
